// File: rtl/sa_down_result_reader_if.sv
// Result stream from the down-SRAM drain engine: one accumulated word per
// transfer, tagged with its column index and an end-of-range marker.
interface sa_down_result_reader_if #(
    parameter int OUT_DATA_WIDTH = 32,
    parameter int LOG2_NUM_COL   = 2
);
    logic [OUT_DATA_WIDTH-1:0] data;
    logic                      valid;
    logic                      ready;
    logic [LOG2_NUM_COL-1:0]   col_idx;
    logic                      last;

    modport master (output data, output valid, output col_idx, output last, input ready);
    modport slave  (input data, input valid, input col_idx, input last, output ready);
endinterface

// File: rtl/sa_down_result_reader.sv
// Drains a range of down-SRAM rows: one read per row, then serializes the
// NUM_COL result words of that row onto a valid/ready stream.
module sa_down_result_reader #(
    parameter int NUM_COL              = 4,
    parameter int OUT_DATA_WIDTH       = 32,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int LOG2_NUM_COL         = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_end_addr,
    output logic                              o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_down_rd_data,
    sa_down_result_reader_if.master           res,
    output logic                              o_busy,
    output logic                              o_done
);
    localparam logic [LOG2_NUM_COL-1:0] LAST_COL = LOG2_NUM_COL'(NUM_COL - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, STREAM, DONE} state_t;

    state_t                              state_r;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     cur_addr_r;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     end_addr_r;
    logic [NUM_COL*OUT_DATA_WIDTH-1:0]   row_r;
    logic [LOG2_NUM_COL-1:0]             col_r;
    logic                                rd_en_r;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     rd_addr_r;
    logic [OUT_DATA_WIDTH-1:0]           data_r;
    logic                                valid_r;
    logic                                last_r;
    logic                                busy_r;
    logic                                done_r;

    logic [LOG2_NUM_COL-1:0]             next_col_s;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     next_addr_s;
    logic                                at_end_s;
    logic                                transfer_s;

    function automatic logic [OUT_DATA_WIDTH-1:0] col_word(
        input logic [NUM_COL*OUT_DATA_WIDTH-1:0] row,
        input logic [LOG2_NUM_COL-1:0]           col
    );
        col_word = row[col*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    endfunction

    // Address increment wraps naturally at the bank depth.
    assign next_col_s  = col_r + 1'b1;
    assign next_addr_s = cur_addr_r + 1'b1;
    assign at_end_s    = (cur_addr_r == end_addr_r);
    assign transfer_s  = valid_r & res.ready;

    assign o_down_rd_en   = rd_en_r;
    assign o_down_rd_addr = rd_addr_r;
    assign res.data       = data_r;
    assign res.valid      = valid_r;
    assign res.col_idx    = col_r;
    assign res.last       = last_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;

    // Drain FSM; every output is set on the edge entering the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cur_addr_r <= '0;
            end_addr_r <= '0;
            row_r      <= '0;
            col_r      <= '0;
            rd_en_r    <= 1'b0;
            rd_addr_r  <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (i_start) begin
                        cur_addr_r <= i_start_addr;
                        end_addr_r <= i_end_addr;
                        rd_addr_r  <= i_start_addr;
                        rd_en_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= READ;
                    end
                end
                READ: begin
                    rd_en_r <= 1'b0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    row_r   <= i_down_rd_data;
                    col_r   <= '0;
                    data_r  <= col_word(i_down_rd_data, '0);
                    valid_r <= 1'b1;
                    last_r  <= at_end_s && (LAST_COL == '0);
                    state_r <= STREAM;
                end
                STREAM: begin
                    if (transfer_s) begin
                        if (col_r != LAST_COL) begin
                            col_r  <= next_col_s;
                            data_r <= col_word(row_r, next_col_s);
                            last_r <= at_end_s && (next_col_s == LAST_COL);
                        end else begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            if (at_end_s) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                cur_addr_r <= next_addr_s;
                                rd_addr_r  <= next_addr_s;
                                rd_en_r    <= 1'b1;
                                state_r    <= READ;
                            end
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sa_down_result_reader.sv
// Directed bench for the down-SRAM result reader: table of drain ranges plus
// a hand-written mid-row reset sequence.
module tb_sa_down_result_reader;
    localparam int NC = 4;
    localparam int W  = 32;
    localparam int A  = 5;
    localparam int LC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [A-1:0]  i_start_addr;
    logic [A-1:0]  i_end_addr;
    logic          o_down_rd_en;
    logic [A-1:0]  o_down_rd_addr;
    logic [NC*W-1:0] i_down_rd_data;
    logic          o_busy;
    logic          o_done;

    int n_vec = 0;
    int n_bad = 0;

    sa_down_result_reader_if #(.OUT_DATA_WIDTH(W), .LOG2_NUM_COL(LC)) sif ();

    sa_down_result_reader #(
        .NUM_COL(NC), .OUT_DATA_WIDTH(W), .LOG2_SRAM_BANK_DEPTH(A), .LOG2_NUM_COL(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_start_addr(i_start_addr), .i_end_addr(i_end_addr),
        .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
        .i_down_rd_data(i_down_rd_data), .res(sif),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // SRAM model: row r, column c holds r*16+c, one-cycle read latency.
    always @(posedge clk) begin
        if (o_down_rd_en) begin
            for (int c = 0; c < NC; c++)
                i_down_rd_data[c*W +: W] <= 32'(int'(o_down_rd_addr) * 16 + c);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_en"},   32'(o_down_rd_en), 32'd0);
        chk({tag, " rd_addr"}, 32'(o_down_rd_addr), 32'd0);
        chk({tag, " data"},    sif.data, 32'd0);
        chk({tag, " valid"},   32'(sif.valid), 32'd0);
        chk({tag, " col_idx"}, 32'(sif.col_idx), 32'd0);
        chk({tag, " last"},    32'(sif.last), 32'd0);
        chk({tag, " busy"},    32'(o_busy), 32'd0);
        chk({tag, " done"},    32'(o_done), 32'd0);
    endtask

    typedef struct {
        logic [A-1:0] s;
        logic [A-1:0] e;
        int           mode;     // 0: ready always 1, 1: alternating with a 5-cycle stall
        int           rows;     // hand-computed ((e-s) mod 32) + 1
        bit           restart;  // pulse i_start (start=9) while busy and during DONE
    } vec_t;

    task automatic run_vec(input vec_t v);
        int  ntx = 0, nrd = 0, stall_left = 5, last_tx_cyc = -10;
        bit  hold = 1'b0, done_seen = 1'b0;
        logic [31:0] hold_data = '0;
        logic [LC-1:0] hold_col = '0;
        logic hold_last = 1'b0;
        int  exp_word, exp_addr;

        @(negedge clk);
        i_start = 1'b1; i_start_addr = v.s; i_end_addr = v.e; sif.ready = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                i_start = 1'b0;
                chk("busy after start", 32'(o_busy), 32'd1);
                chk("rd_en in T0..T1", 32'(o_down_rd_en), 32'd1);
            end
            if (cyc == 1) begin
                chk("rd_en after READ", 32'(o_down_rd_en), 32'd0);
                chk("valid before T2", 32'(sif.valid), 32'd0);
            end
            if (cyc == 2) chk("valid at T2", 32'(sif.valid), 32'd1);
            if (v.restart && cyc == 3) begin
                i_start = 1'b1; i_start_addr = 5'd9; i_end_addr = 5'd9;
            end
            if (v.restart && cyc == 4) i_start = 1'b0;
            if (hold) begin
                chk("stall valid", 32'(sif.valid), 32'd1);
                chk("stall data", sif.data, hold_data);
                chk("stall col_idx", 32'(sif.col_idx), 32'(hold_col));
                chk("stall last", 32'(sif.last), 32'(hold_last));
            end
            if (o_down_rd_en) begin
                exp_addr = (int'(v.s) + nrd) % 32;
                chk("rd_addr", 32'(o_down_rd_addr), 32'(exp_addr));
                nrd++;
            end
            if (o_done) begin
                done_seen = 1'b1;
                chk("words at done", 32'(ntx), 32'(v.rows * NC));
                chk("done follows last transfer", 32'(cyc), 32'(last_tx_cyc + 1));
                chk("busy with done", 32'(o_busy), 32'd0);
                chk("rd_en count", 32'(nrd), 32'(v.rows));
                if (v.restart) begin
                    i_start = 1'b1; i_start_addr = 5'd9; i_end_addr = 5'd9;
                end
            end
            if (v.mode == 1) begin
                if (ntx == 6 && stall_left > 0) begin
                    sif.ready = 1'b0;
                    stall_left--;
                end else begin
                    sif.ready = (cyc % 2 == 0);
                end
            end else begin
                sif.ready = 1'b1;
            end
            if (sif.valid && sif.ready) begin
                exp_word = ((int'(v.s) + ntx / NC) % 32) * 16 + ntx % NC;
                chk("word", sif.data, 32'(exp_word));
                chk("col_idx", 32'(sif.col_idx), 32'(ntx % NC));
                chk("last", 32'(sif.last), 32'(ntx == v.rows * NC - 1));
                ntx++;
                last_tx_cyc = cyc;
                hold = 1'b0;
            end else begin
                hold = sif.valid;
                hold_data = sif.data;
                hold_col = sif.col_idx;
                hold_last = sif.last;
            end
        end
        if (!done_seen) chk("done timeout", 32'd0, 32'd1);
        sif.ready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        chk("idle rd_en", 32'(o_down_rd_en), 32'd0);
        chk("idle busy", 32'(o_busy), 32'd0);
        chk("idle done", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("ignored start rd_en", 32'(o_down_rd_en), 32'd0);
        chk("ignored start busy", 32'(o_busy), 32'd0);
    endtask

    vec_t tbl [5];

    initial begin
        bit hit;
        tbl[0] = '{s: 5'd0,  e: 5'd3, mode: 0, rows: 4, restart: 1'b0};
        tbl[1] = '{s: 5'd0,  e: 5'd3, mode: 1, rows: 4, restart: 1'b0};
        tbl[2] = '{s: 5'd30, e: 5'd1, mode: 0, rows: 4, restart: 1'b0};
        tbl[3] = '{s: 5'd7,  e: 5'd7, mode: 0, rows: 1, restart: 1'b0};
        tbl[4] = '{s: 5'd0,  e: 5'd3, mode: 0, rows: 4, restart: 1'b1};

        rst_n = 1'b0; i_start = 1'b0; i_start_addr = '0; i_end_addr = '0;
        sif.ready = 1'b0; i_down_rd_data = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reset mid-row 1 of range 0..3, then a fresh single-row drain of row 2.
        @(negedge clk);
        i_start = 1'b1; i_start_addr = 5'd0; i_end_addr = 5'd3; sif.ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            @(negedge clk);
            if (sif.valid && sif.data == 32'd17) hit = 1'b1;
        end
        chk("reached mid-row 1", 32'(hit), 32'd1);
        sif.ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-op reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{s: 5'd2, e: 5'd2, mode: 0, rows: 1, restart: 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sa_down_result_reader.md
Name: sa_down_result_reader

Overview:
- Host-side drain engine for the systolic array's output (down) SRAM bank. It is the read-side counterpart to the top/left buffer write path.
- On a start pulse it walks an address range of the down SRAM, issuing one read per row. It captures each NUM_COL-wide result row and serializes it into a valid/ready stream of OUT_DATA_WIDTH words.
- It sits between systolic_array_top (i_down_rd_en / i_down_rd_addr / o_down_rd_data) and the result consumer (DMA or host).

Parameters:
- NUM_COL, 4, number of PE columns (words per SRAM row).
- OUT_DATA_WIDTH, 32, width of one accumulated result word.
- LOG2_SRAM_BANK_DEPTH, 5, down SRAM address width; depth = 2**LOG2_SRAM_BANK_DEPTH.
- LOG2_NUM_COL, 2, column index width; must satisfy 2**LOG2_NUM_COL >= NUM_COL.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1.
- i_start_addr  in  LOG2_SRAM_BANK_DEPTH  first row address, sampled with i_start.
- i_end_addr  in  LOG2_SRAM_BANK_DEPTH  last row address (inclusive), sampled with i_start.
- o_down_rd_en  out  1  read enable to the down SRAM.
- o_down_rd_addr  out  LOG2_SRAM_BANK_DEPTH  read address to the down SRAM.
- i_down_rd_data  in  NUM_COL*OUT_DATA_WIDTH  SRAM read data, valid one cycle after o_down_rd_en.
- o_data  out  OUT_DATA_WIDTH  streamed result word.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  consumer accepts; a transfer occurs when o_valid & i_ready at a rising edge.
- o_col_idx  out  LOG2_NUM_COL  column index of the current o_data.
- o_last  out  1  high with the final word of the final row.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; row register and counters cleared.
- All outputs are registered.
- FSM states: IDLE, READ, WAIT, STREAM, DONE.
- IDLE: on i_start, latch start/end addresses, set cur_addr=i_start_addr, set o_busy=1, go READ.
- READ (1 cycle): o_down_rd_en=1, o_down_rd_addr=cur_addr. Go WAIT.
  - o_down_rd_en is high for exactly one cycle per row; 0 in every other state.
  - o_down_rd_addr holds its last value when rd_en=0.
- WAIT (1 cycle): on the closing edge, capture i_down_rd_data into the row register, set col=0, o_valid=1. Go STREAM.
- STREAM:
  - o_data = row[col*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]; column 0 is the LSB slice; o_col_idx=col.
  - On transfer with col<NUM_COL-1: col+1, o_valid stays 1.
  - On transfer of col=NUM_COL-1:
    - If cur_addr==end: o_valid=0, o_last=0, go DONE.
    - Otherwise: cur_addr=cur_addr+1 modulo 2**LOG2_SRAM_BANK_DEPTH, o_valid=0, go READ.
- Backpressure: while o_valid & ~i_ready, o_data, o_col_idx and o_last hold stable. o_valid never drops without a transfer.
- o_last=1 only when cur_addr==end and col==NUM_COL-1 while o_valid=1.
- DONE (1 cycle): o_done=1, o_busy=0. Go IDLE.
- Latency:
  - i_start sampled at edge T0; o_down_rd_en=1 during cycle T0..T1; row captured at T2; o_valid=1 from T2.
  - Each subsequent row costs 2 bubble cycles (READ, WAIT) after its predecessor's last transfer.
- Range: rows read = ((end - start) mod depth) + 1.
  - start==end reads one row.
  - start>end wraps through address depth-1 to 0.
- i_start while busy (including the DONE cycle): ignored; addresses are not re-latched.
- i_down_rd_data is sampled only at the WAIT-closing edge; other cycles are don't-care.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the partially streamed row is discarded.

Test Plan:
- SRAM model where row r, column c holds r*16+c; start=0, end=3, i_ready=1. Required:
  - rd_en pulses at addresses 0,1,2,3.
  - 16 words in order: 0,1,2,3,16,17,18,19,32,…,51.
  - o_col_idx cycles 0..3; o_last only on 51; o_done one cycle after the 51 transfer; o_busy falls with o_done.
- Same setup with i_ready patterned 1,0,1,0 plus one 5-cycle low stall mid-row. Required: identical word sequence, no drops or duplicates, o_data/o_col_idx stable during every stall.
- Wrap: start=30, end=1. Required: rd_en addresses 30,31,0,1; 16 words starting 480 (30*16); o_last on word 19.
- Single row: start=end=7. Required: one rd_en at address 7; words 112,113,114,115; o_last on 115.
- Start at edge T0. Required: o_down_rd_en high only in cycle T0..T1; o_valid rises at T2; a second i_start during busy with start=9 is ignored (addresses unchanged).
- Assert rst_n=0 mid-row 1 of range 0..3. Required: all outputs 0 immediately. After release, a new start=2, end=2 yields exactly 32,33,34,35.
